flash_byte_prog_ctrl: RTL and testbench

//  Consumes the UART receive byte stream (pi_flag/pi_data) and programs each byte into SPI NOR flash.

---
 rtl/flash_byte_prog_ctrl_pkg.sv | 29 ++
 rtl/flash_byte_prog_ctrl_byte_fifo.sv | 47 ++++
 rtl/flash_byte_prog_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_flash_byte_prog_ctrl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/flash_byte_prog_ctrl_pkg.sv
// Shared opcodes, FSM encoding and SPI frame layout for the UART-to-flash byte programmer.
package flash_byte_prog_ctrl_pkg;

  localparam logic [7:0] CMD_WREN = 8'h06;
  localparam logic [7:0] CMD_PP   = 8'h02;
  localparam logic [7:0] CMD_SE   = 8'hD8;

  localparam int unsigned ADDR_W    = 24;
  localparam int unsigned FRAME_W   = 40;
  localparam int unsigned BIT_CNT_W = 6;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WREN    = 3'd1,
    S_GAP     = 3'd2,
    S_PROG    = 3'd3,
    S_WAIT    = 3'd4,
    S_SE      = 3'd5,
    S_SE_WAIT = 3'd6
  } state_e;

  // Longest frame, left-aligned: shorter commands shift out only their leading bits.
  typedef struct packed {
    logic [7:0]        op;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
  } frame_t;

endpackage

// File: rtl/flash_byte_prog_ctrl_byte_fifo.sv
// Synchronous byte FIFO; rd_data is registered and valid the cycle after rd_en.
module byte_fifo #(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic          full,
  output logic          empty
);

  localparam int unsigned PW = AW + 1;

  logic [DW-1:0] mem [2**AW];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic          do_wr;
  logic          do_rd;

  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;
  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

  always_ff @(posedge clk) begin
    if (do_wr) mem[wptr[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr    <= '0;
      rptr    <= '0;
      rd_data <= '0;
    end else begin
      if (do_wr) wptr <= wptr + PW'(1);
      if (do_rd) begin
        rd_data <= mem[rptr[AW-1:0]];
        rptr    <= rptr + PW'(1);
      end
    end
  end

endmodule

// File: rtl/flash_byte_prog_ctrl.sv
// Programs each received UART byte into SPI NOR flash at consecutive addresses (WREN + PAGE PROGRAM).
// Define FLASH_SE_EN to sector-erase START_ADDR once before the first byte after reset.
module flash_byte_prog_ctrl
  import flash_byte_prog_ctrl_pkg::*;
#(
`ifdef FLASH_SE_EN
  parameter int unsigned        T_SE_CYC   = 150_000_000,
`endif
  parameter logic [ADDR_W-1:0]  START_ADDR = 24'h00_0000,
  parameter int unsigned        FIFO_AW    = 4,
  parameter int unsigned        CS_GAP_CYC = 8,
  parameter int unsigned        T_PP_CYC   = 50_000
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       pi_flag,
  input  logic [7:0] pi_data,
  output logic       sck,
  output logic       cs_n,
  output logic       mosi,
  output logic       busy,
  output logic       ovf
);

  localparam int unsigned WAIT_MAX0 = (T_PP_CYC > CS_GAP_CYC) ? T_PP_CYC : CS_GAP_CYC;
`ifdef FLASH_SE_EN
  localparam int unsigned WAIT_MAX  = (T_SE_CYC > WAIT_MAX0) ? T_SE_CYC : WAIT_MAX0;
`else
  localparam int unsigned WAIT_MAX  = WAIT_MAX0;
`endif
  localparam int unsigned WAIT_W    = ($clog2(WAIT_MAX) < 1) ? 1 : $clog2(WAIT_MAX);

  state_e               state, state_d;
  logic                 flag_r;
  logic [7:0]           byte_r;
  logic [7:0]           data_r;
  logic                 full, empty;
  logic                 pop_c;
  logic [1:0]           ph;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic [FRAME_W-1:0]   sr;
  logic [WAIT_W-1:0]    wait_cnt;
  logic [ADDR_W-1:0]    addr;
  logic                 last_bit_c;
  logic                 ld_frame, end_frame, ld_wait, addr_inc;
  frame_t               word_d;
  logic [BIT_CNT_W-1:0] bits_d;
  logic [WAIT_W-1:0]    wait_d;
`ifdef FLASH_SE_EN
  logic                 se_done;
  logic                 se_set;
`endif

  // Received bytes are registered once before entering the FIFO.
  byte_fifo #(.DW(8), .AW(FIFO_AW)) u_fifo (
    .clk     (sys_clk),
    .rst_n   (sys_rst_n),
    .wr_en   (flag_r && !full),
    .wr_data (byte_r),
    .rd_en   (pop_c),
    .rd_data (data_r),
    .full    (full),
    .empty   (empty)
  );

  assign last_bit_c = (ph == 2'd3) && (bit_cnt == '0);

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) state <= S_IDLE;
    else            state <= state_d;
  end

  // Sequencing: frame loads, wait loads and state transitions.
  always_comb begin
    state_d   = state;
    pop_c     = 1'b0;
    ld_frame  = 1'b0;
    end_frame = 1'b0;
    ld_wait   = 1'b0;
    addr_inc  = 1'b0;
    word_d    = '0;
    bits_d    = '0;
    wait_d    = '0;
`ifdef FLASH_SE_EN
    se_set    = 1'b0;
`endif
    case (state)
      S_IDLE: if (!empty) begin
        pop_c    = 1'b1;
        ld_frame = 1'b1;
        word_d   = '{op: CMD_WREN, addr: '0, data: '0};
        bits_d   = BIT_CNT_W'(7);
        state_d  = S_WREN;
      end
      S_WREN: if (last_bit_c) begin
        end_frame = 1'b1;
        ld_wait   = 1'b1;
        wait_d    = WAIT_W'(CS_GAP_CYC - 1);
        state_d   = S_GAP;
      end
      S_GAP: if (wait_cnt == '0) begin
        ld_frame = 1'b1;
`ifdef FLASH_SE_EN
        if (!se_done) begin
          word_d  = '{op: CMD_SE, addr: addr, data: '0};
          bits_d  = BIT_CNT_W'(31);
          state_d = S_SE;
        end else
`endif
        begin
          word_d  = '{op: CMD_PP, addr: addr, data: data_r};
          bits_d  = BIT_CNT_W'(39);
          state_d = S_PROG;
        end
      end
      S_PROG: if (last_bit_c) begin
        end_frame = 1'b1;
        ld_wait   = 1'b1;
        wait_d    = WAIT_W'(T_PP_CYC - 1);
        state_d   = S_WAIT;
      end
      S_WAIT: if (wait_cnt == '0) begin
        addr_inc = 1'b1;
        state_d  = S_IDLE;
      end
`ifdef FLASH_SE_EN
      S_SE: if (last_bit_c) begin
        end_frame = 1'b1;
        ld_wait   = 1'b1;
        wait_d    = WAIT_W'(T_SE_CYC - 1);
        state_d   = S_SE_WAIT;
      end
      S_SE_WAIT: if (wait_cnt == '0) begin
        se_set   = 1'b1;
        ld_frame = 1'b1;
        word_d   = '{op: CMD_WREN, addr: '0, data: '0};
        bits_d   = BIT_CNT_W'(7);
        state_d  = S_WREN;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // SPI pins, counters, address and status; sck high in ph 2,3, mosi changes entering ph 0.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      flag_r   <= 1'b0;
      byte_r   <= '0;
      ovf      <= 1'b0;
      busy     <= 1'b0;
      cs_n     <= 1'b1;
      sck      <= 1'b0;
      mosi     <= 1'b0;
      ph       <= '0;
      bit_cnt  <= '0;
      sr       <= '0;
      wait_cnt <= '0;
      addr     <= START_ADDR;
`ifdef FLASH_SE_EN
      se_done  <= 1'b0;
`endif
    end else begin
      flag_r <= pi_flag;
      byte_r <= pi_data;
      if (flag_r && full) ovf <= 1'b1;
      busy <= (state_d != S_IDLE) || !empty || flag_r;

      if (ld_frame) begin
        cs_n    <= 1'b0;
        sck     <= 1'b0;
        ph      <= '0;
        mosi    <= word_d.op[7];
        sr      <= {word_d[FRAME_W-2:0], 1'b0};
        bit_cnt <= bits_d;
      end else if (end_frame) begin
        cs_n <= 1'b1;
        sck  <= 1'b0;
        ph   <= '0;
      end else if (!cs_n) begin
        ph  <= ph + 2'd1;
        sck <= (ph == 2'd1) || (ph == 2'd2);
        if (ph == 2'd3) begin
          mosi    <= sr[FRAME_W-1];
          sr      <= {sr[FRAME_W-2:0], 1'b0};
          bit_cnt <= bit_cnt - BIT_CNT_W'(1);
        end
      end

      if (ld_wait)              wait_cnt <= wait_d;
      else if (wait_cnt != '0)  wait_cnt <= wait_cnt - WAIT_W'(1);

      if (addr_inc) addr <= addr + ADDR_W'(1);
`ifdef FLASH_SE_EN
      if (se_set) se_done <= 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_flash_byte_prog_ctrl.sv
// Directed bench for flash_byte_prog_ctrl with a mode-0 SPI flash slave that logs frames.
module tb_flash_byte_prog_ctrl;

  localparam logic [23:0] START = 24'hFF_FFFE;
  localparam int unsigned GAP   = 8;
  localparam int unsigned T_PP  = 300;
  localparam int unsigned T_SE  = 500;
`ifdef FLASH_SE_EN
  localparam bit SE_ON = 1'b1;
`else
  localparam bit SE_ON = 1'b0;
`endif

  logic       sys_clk, sys_rst_n, pi_flag;
  logic [7:0] pi_data;
  logic       sck, cs_n, mosi, busy, ovf;

  int total = 0;
  int bad   = 0;

  // Frame log entries are {bit count, bits received right-aligned}.
  logic [47:0] frm_q[$];
  logic [47:0] exp_q[$];
  int          frm_s[$];
  int          frm_e[$];
  int          cyc, busy_fall, nb;
  logic [39:0] sv;
  logic        p_sck, p_cs, p_busy;
  bit          sck_bad;

  flash_byte_prog_ctrl #(
`ifdef FLASH_SE_EN
    .T_SE_CYC   (T_SE),
`endif
    .START_ADDR (START),
    .FIFO_AW    (4),
    .CS_GAP_CYC (GAP),
    .T_PP_CYC   (T_PP)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .pi_flag   (pi_flag),
    .pi_data   (pi_data),
    .sck       (sck),
    .cs_n      (cs_n),
    .mosi      (mosi),
    .busy      (busy),
    .ovf       (ovf)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  // Flash slave: samples pins each clock, shifts mosi on sck rise while selected.
  initial begin
    cyc = 0; nb = 0; sv = '0; busy_fall = 0;
    p_sck = 1'b0; p_cs = 1'b1; p_busy = 1'b0; sck_bad = 1'b0;
    forever begin
      @(posedge sys_clk);
      cyc++;
      if (p_cs === 1'b1 && cs_n === 1'b0) begin
        nb = 0;
        sv = '0;
        frm_s.push_back(cyc);
      end
      if (cs_n === 1'b0 && p_sck !== 1'b1 && sck === 1'b1) begin
        sv = {sv[38:0], mosi};
        nb++;
      end
      if (p_cs === 1'b0 && cs_n === 1'b1) begin
        frm_q.push_back({8'(nb), sv});
        frm_e.push_back(cyc);
      end
      if (cs_n === 1'b1 && sck === 1'b1) sck_bad = 1'b1;
      if (p_busy === 1'b1 && busy === 1'b0) busy_fall = cyc;
      p_sck  = sck;
      p_cs   = cs_n;
      p_busy = busy;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_logs();
    frm_q.delete();
    exp_q.delete();
    frm_s.delete();
    frm_e.delete();
  endtask

  task automatic exp_byte(input logic [23:0] a, input logic [7:0] d, input bit first);
    exp_q.push_back({8'd8, 32'h0, 8'h06});
    if (first && SE_ON) begin
      exp_q.push_back({8'd32, 8'h00, 8'hD8, START});
      exp_q.push_back({8'd8, 32'h0, 8'h06});
    end
    exp_q.push_back({8'd40, 8'h02, a, d});
  endtask

  task automatic check_frames(input string tag);
    chk({tag, "_count"}, 64'(frm_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < frm_q.size(); i++)
      chk($sformatf("%s_frame%0d", tag, i), 64'(frm_q[i]), 64'(exp_q[i]));
  endtask

  task automatic do_reset();
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
    pi_flag   = 1'b0;
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    clear_logs();
  endtask

  task automatic send(input logic [7:0] d);
    @(negedge sys_clk);
    pi_flag = 1'b1;
    pi_data = d;
    @(negedge sys_clk);
    pi_flag = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int max);
    int n = 0;
    repeat (4) @(posedge sys_clk);
    #1;
    while (busy !== 1'b0 && n < max) begin
      @(posedge sys_clk);
      #1;
      n++;
    end
    chk({tag, "_idle_in_time"}, 64'(n < max), 64'(1));
    @(posedge sys_clk);
    #1;
  endtask

  initial begin
    int n;
    int snap;
    sys_rst_n = 1'b0;
    pi_flag   = 1'b0;
    pi_data   = '0;
    do_reset();

    // Reset state
    chk("rst_cs_n", 64'(cs_n), 64'(1));
    chk("rst_sck",  64'(sck),  64'(0));
    chk("rst_mosi", 64'(mosi), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_ovf",  64'(ovf),  64'(0));

    // Single byte: latency, frames, gap, frame length, busy drop
    @(negedge sys_clk);
    pi_flag = 1'b1;
    pi_data = 8'hA5;
    @(posedge sys_clk); #1;
    chk("t1_cs_n_edge_n", 64'(cs_n), 64'(1));
    @(negedge sys_clk);
    pi_flag = 1'b0;
    @(posedge sys_clk); #1;
    chk("t1_cs_n_edge_n1", 64'(cs_n), 64'(1));
    chk("t1_busy_edge_n1", 64'(busy), 64'(1));
    @(posedge sys_clk); #1;
    chk("t1_cs_n_edge_n2", 64'(cs_n), 64'(0));
    exp_byte(START, 8'hA5, 1'b1);
    wait_idle("t1", 20000);
    check_frames("t1");
    n = frm_e.size();
    if (n >= 2 && frm_s.size() == n) begin
      chk("t1_wren_len",   64'(frm_e[n-2] - frm_s[n-2]), 64'(32));
      chk("t1_gap",        64'(frm_s[n-1] - frm_e[n-2]), 64'(GAP));
      chk("t1_pp_len",     64'(frm_e[n-1] - frm_s[n-1]), 64'(160));
      chk("t1_busy_drop",  64'(busy_fall - frm_e[n-1]), 64'(T_PP));
    end
`ifdef FLASH_SE_EN
    if (n >= 4 && frm_s.size() == n) begin
      chk("t1_se_gap",  64'(frm_s[1] - frm_e[0]), 64'(GAP));
      chk("t1_se_len",  64'(frm_e[1] - frm_s[1]), 64'(128));
      chk("t1_se_wait", 64'(frm_s[2] - frm_e[1]), 64'(T_SE));
    end
`endif

    // Burst of five bytes, two cycles apart; addresses wrap past FFFFFF
    clear_logs();
    for (int i = 0; i < 5; i++) begin
      send(8'h11 + 8'(i));
      exp_byte(START + 24'(i + 1), 8'h11 + 8'(i), 1'b0);
    end
    wait_idle("t2", 20000);
    check_frames("t2");
    chk("t2_ovf", 64'(ovf), 64'(0));

    // Overflow: 20 back-to-back bytes, 17 survive
    do_reset();
    @(negedge sys_clk);
    for (int i = 0; i < 20; i++) begin
      pi_flag = 1'b1;
      pi_data = 8'h40 + 8'(i);
      @(negedge sys_clk);
    end
    pi_flag = 1'b0;
    for (int i = 0; i < 17; i++) exp_byte(START + 24'(i), 8'h40 + 8'(i), i == 0);
    wait_idle("t3", 30000);
    check_frames("t3");
    chk("t3_ovf_set", 64'(ovf), 64'(1));
    repeat (20) @(posedge sys_clk);
    #1;
    chk("t3_ovf_sticky", 64'(ovf), 64'(1));
    do_reset();
    chk("t3_ovf_cleared", 64'(ovf), 64'(0));

    // Reset during PP at bit 20
    send(8'h77);
    n = 0;
    while (!(nb == 20 && sv[19:12] == 8'h02) && n < 5000) begin
      @(posedge sys_clk);
      #1;
      n++;
    end
    chk("t5_reached_bit20", 64'(n < 5000), 64'(1));
    sys_rst_n = 1'b0;
    @(posedge sys_clk); #1;
    chk("t5_cs_n_abort", 64'(cs_n), 64'(1));
    chk("t5_sck_abort",  64'(sck),  64'(0));
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (2) @(posedge sys_clk);
    snap = frm_q.size();
    repeat (1000) @(posedge sys_clk);
    #1;
    chk("t5_no_more_frames", 64'(frm_q.size()), 64'(snap));
    chk("t5_idle_busy", 64'(busy), 64'(0));
    chk("t5_idle_cs_n", 64'(cs_n), 64'(1));
    clear_logs();
    send(8'h88);
    exp_byte(START, 8'h88, 1'b1);
    wait_idle("t5", 20000);
    check_frames("t5");

    chk("sck_low_while_deselected", 64'(sck_bad), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
